// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the writeback stage
package wb_pkg;

    localparam int WB_XLEN     = 64;
    localparam int WB_NUM_REGS = 32;

    typedef enum logic [1:0] {
        LS_B = 2'b00,
        LS_H = 2'b01,
        LS_W = 2'b10,
        LS_D = 2'b11
    } load_size_e;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// rtl/wb_writeback_unit_if.sv - MEM/WB, data-memory response, read-port and commit signals
// Ports: master = pipeline/memory side (drives MEM/WB fields, memory data, read
// addresses); slave = writeback unit (returns read data, stall, commit, instret).
interface wb_writeback_unit_if import wb_pkg::*; #(parameter int XLEN = WB_XLEN);
    logic            flush;
    logic            wb_valid_in;
    logic            reg_write_in;
    logic            mem_to_reg_in;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] alu_result_in;
    logic [1:0]      load_size_in;
    logic            load_unsigned_in;
    logic [2:0]      load_addr_lo_in;
    logic            mem_rdata_valid;
    logic [XLEN-1:0] mem_rdata;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_stall;
    logic            rf_we_out;
    logic [4:0]      rf_waddr_out;
    logic [XLEN-1:0] rf_wdata_out;
    logic [63:0]     instret;

    modport master (
        output flush, wb_valid_in, reg_write_in, mem_to_reg_in, rd_in, alu_result_in,
               load_size_in, load_unsigned_in, load_addr_lo_in, mem_rdata_valid,
               mem_rdata, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_stall, rf_we_out, rf_waddr_out, rf_wdata_out, instret
    );

    modport slave (
        input  flush, wb_valid_in, reg_write_in, mem_to_reg_in, rd_in, alu_result_in,
               load_size_in, load_unsigned_in, load_addr_lo_in, mem_rdata_valid,
               mem_rdata, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_stall, rf_we_out, rf_waddr_out, rf_wdata_out, instret
    );
endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - extract, truncate and extend a load from a naturally aligned word
// Ports: raw (memory word), size, is_unsigned, addr_lo (byte offset) -> value (XLEN result).
module wb_load_align import wb_pkg::*; #(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] raw,
    input  load_size_e      size,
    input  logic            is_unsigned,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] value
);
    logic [2:0]      shift_lo;
    logic [XLEN-1:0] lane;
    logic            sext;

    always_comb begin
        shift_lo = 3'd0;
        // Low offset bits below the access size are ignored (natural alignment).
        case (size)
            LS_B:    shift_lo = addr_lo;
            LS_H:    shift_lo = {addr_lo[2:1], 1'b0};
            LS_W:    shift_lo = {addr_lo[2], 2'b00};
            default: shift_lo = 3'd0;
        endcase
        lane  = raw >> {shift_lo, 3'b000};
        sext  = ~is_unsigned;
        value = lane;
        case (size)
            LS_B:    value = {{(XLEN-8){sext & lane[7]}},   lane[7:0]};
            LS_H:    value = {{(XLEN-16){sext & lane[15]}}, lane[15:0]};
            LS_W:    value = {{(XLEN-32){sext & lane[31]}}, lane[31:0]};
            default: value = lane;
        endcase
    end
endmodule

// File: rtl/wb_writeback_unit.sv
// rtl/wb_writeback_unit.sv - writeback stage: load completion FSM, register file, bypassed reads, instret
// Ports: clk, reset (async active-high), bus (slave modport of wb_writeback_unit_if).
module wb_writeback_unit import wb_pkg::*; #(
    parameter int XLEN     = WB_XLEN,
    parameter int NUM_REGS = WB_NUM_REGS
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_writeback_unit_if.slave   bus
);
    wb_state_e       state_q, state_d;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [63:0]     instret_q;

    logic [4:0]      p_rd;
    load_size_e      p_size;
    logic            p_unsigned;
    logic [2:0]      p_addr_lo;

    logic            latch_en;
    logic            commit;
    logic            commit_write;
    logic            from_mem;
    logic            stall;
    logic [4:0]      c_rd;
    load_size_e      c_size;
    logic            c_unsigned;
    logic [2:0]      c_addr_lo;
    logic [XLEN-1:0] load_value;

    always_comb begin
        state_d      = state_q;
        latch_en     = 1'b0;
        commit       = 1'b0;
        commit_write = 1'b0;
        from_mem     = 1'b0;
        stall        = 1'b0;
        c_rd         = bus.rd_in;
        c_size       = load_size_e'(bus.load_size_in);
        c_unsigned   = bus.load_unsigned_in;
        c_addr_lo    = bus.load_addr_lo_in;
        case (state_q)
            WB_IDLE: begin
                if (bus.wb_valid_in && !bus.flush) begin
                    if (bus.mem_to_reg_in || !bus.reg_write_in) begin
                        commit       = 1'b1;
                        commit_write = bus.reg_write_in;
                    end else if (bus.mem_rdata_valid) begin
                        commit       = 1'b1;
                        commit_write = 1'b1;
                        from_mem     = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        stall    = 1'b1;
                        state_d  = WB_WAIT_MEM;
                    end
                end
            end
            WB_WAIT_MEM: begin
                // Only loads that write ever wait, so the commit always writes.
                c_rd       = p_rd;
                c_size     = p_size;
                c_unsigned = p_unsigned;
                c_addr_lo  = p_addr_lo;
                if (bus.flush) begin
                    state_d = WB_IDLE;
                end else if (bus.mem_rdata_valid) begin
                    commit       = 1'b1;
                    commit_write = 1'b1;
                    from_mem     = 1'b1;
                    state_d      = WB_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = WB_IDLE;
        endcase
        // Outputs read as idle while reset is held, even between clock edges.
        if (reset) begin
            commit       = 1'b0;
            commit_write = 1'b0;
            stall        = 1'b0;
        end
    end

    wb_load_align #(.XLEN(XLEN)) u_align (
        .raw         (bus.mem_rdata),
        .size        (c_size),
        .is_unsigned (c_unsigned),
        .addr_lo     (c_addr_lo),
        .value       (load_value)
    );

    assign bus.wb_stall     = stall;
    assign bus.rf_we_out    = commit_write && (c_rd != 5'd0);
    assign bus.rf_waddr_out = c_rd;
    assign bus.rf_wdata_out = from_mem ? load_value : bus.alu_result_in;
    assign bus.instret      = instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WB_IDLE;
            instret_q  <= 64'd0;
            p_rd       <= 5'd0;
            p_size     <= LS_B;
            p_unsigned <= 1'b0;
            p_addr_lo  <= 3'd0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            if (commit) instret_q <= instret_q + 64'd1;
            if (latch_en) begin
                p_rd       <= bus.rd_in;
                p_size     <= load_size_e'(bus.load_size_in);
                p_unsigned <= bus.load_unsigned_in;
                p_addr_lo  <= bus.load_addr_lo_in;
            end
            if (bus.rf_we_out) regs[bus.rf_waddr_out] <= bus.rf_wdata_out;
        end
    end

    // Write-through: a same-cycle commit to the addressed register wins over the array.
    always_comb begin
        bus.rs1_data = regs[bus.rs1_addr];
        bus.rs2_data = regs[bus.rs2_addr];
        if (bus.rf_we_out && bus.rf_waddr_out == bus.rs1_addr) bus.rs1_data = bus.rf_wdata_out;
        if (bus.rf_we_out && bus.rf_waddr_out == bus.rs2_addr) bus.rs2_data = bus.rf_wdata_out;
        if (bus.rs1_addr == 5'd0) bus.rs1_data = '0;
        if (bus.rs2_addr == 5'd0) bus.rs2_data = '0;
    end
endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb/tb_wb_writeback_unit.sv - self-checking bench for wb_writeback_unit
module tb_wb_writeback_unit;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] exp_instret;

    always #5 clk = ~clk;

    wb_writeback_unit_if #(.XLEN(64)) bus ();

    wb_writeback_unit #(.XLEN(64), .NUM_REGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  lo;
        logic [63:0] rdata;
        logic [4:0]  rs1;
        logic        exp_we;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rs1;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.flush            = 1'b0;
        bus.wb_valid_in      = 1'b0;
        bus.reg_write_in     = 1'b0;
        bus.mem_to_reg_in    = 1'b1;
        bus.rd_in            = 5'd0;
        bus.alu_result_in    = 64'd0;
        bus.load_size_in     = 2'b00;
        bus.load_unsigned_in = 1'b0;
        bus.load_addr_lo_in  = 3'd0;
        bus.mem_rdata_valid  = 1'b0;
        bus.mem_rdata        = 64'd0;
        bus.rs1_addr         = 5'd0;
        bus.rs2_addr         = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                              input logic [2:0] lo, input logic rv, input logic [63:0] rdata);
        bus.wb_valid_in      = 1'b1;
        bus.reg_write_in     = 1'b1;
        bus.mem_to_reg_in    = 1'b0;
        bus.rd_in            = rd;
        bus.load_size_in     = size;
        bus.load_unsigned_in = uns;
        bus.load_addr_lo_in  = lo;
        bus.mem_rdata_valid  = rv;
        bus.mem_rdata        = rdata;
    endtask

    initial begin
        //          rw    m2r   rd     alu              sz     uns   lo    rdata                   rs1    we    wdata                   rs1 data
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  64'h1234, 2'b00, 1'b0, 3'd0, 64'h0,                  5'd5,  1'b1, 64'h1234,               64'h1234};
        vecs[1]  = '{1'b1, 1'b0, 5'd6,  64'h0,    2'b00, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 5'd6,  1'b1, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 5'd6,  64'h0,    2'b00, 1'b1, 3'd3, 64'h0000_0000_8000_0000, 5'd6,  1'b1, 64'h80,                 64'h80};
        vecs[3]  = '{1'b1, 1'b0, 5'd8,  64'h0,    2'b01, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 5'd8,  1'b1, 64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_FFFF_FFFF_8000};
        vecs[4]  = '{1'b1, 1'b0, 5'd10, 64'h0,    2'b10, 1'b1, 3'd4, 64'h8765_4321_0000_0000, 5'd10, 1'b1, 64'h8765_4321,          64'h8765_4321};
        vecs[5]  = '{1'b1, 1'b0, 5'd11, 64'h0,    2'b11, 1'b0, 3'd5, 64'h0123_4567_89AB_CDEF, 5'd11, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{1'b1, 1'b0, 5'd12, 64'h0,    2'b01, 1'b1, 3'd6, 64'hBEEF_0000_0000_0000, 5'd12, 1'b1, 64'hBEEF,               64'hBEEF};
        vecs[7]  = '{1'b1, 1'b1, 5'd0,  64'hDEAD, 2'b00, 1'b0, 3'd0, 64'h0,                  5'd0,  1'b0, 64'h0,                  64'h0};
        vecs[8]  = '{1'b0, 1'b1, 5'd9,  64'h5555, 2'b00, 1'b0, 3'd0, 64'h0,                  5'd5,  1'b0, 64'h0,                  64'h1234};
        vecs[9]  = '{1'b1, 1'b0, 5'd13, 64'h0,    2'b00, 1'b0, 3'd0, 64'h0000_0000_0000_007F, 5'd13, 1'b1, 64'h7F,                 64'h7F};
        vecs[10] = '{1'b1, 1'b0, 5'd14, 64'h0,    2'b10, 1'b0, 3'd0, 64'hFFFF_FFFF_7FFF_FFFF, 5'd14, 1'b1, 64'h7FFF_FFFF,          64'h7FFF_FFFF};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.rs1_addr = 5'd5;
        #1;
        chk("reset_stall", {63'd0, bus.wb_stall}, 64'd0);
        chk("reset_we", {63'd0, bus.rf_we_out}, 64'd0);
        chk("reset_instret", bus.instret, 64'd0);
        chk("reset_x5", bus.rs1_data, 64'd0);
        exp_instret = 64'd0;

        // Single-cycle commits: ALU, hit loads, x0 write, no-write instruction.
        for (int i = 0; i < 11; i++) begin
            bus.wb_valid_in      = 1'b1;
            bus.reg_write_in     = vecs[i].rw;
            bus.mem_to_reg_in    = vecs[i].m2r;
            bus.rd_in            = vecs[i].rd;
            bus.alu_result_in    = vecs[i].alu;
            bus.load_size_in     = vecs[i].size;
            bus.load_unsigned_in = vecs[i].uns;
            bus.load_addr_lo_in  = vecs[i].lo;
            bus.mem_rdata_valid  = 1'b1;
            bus.mem_rdata        = vecs[i].rdata;
            bus.rs1_addr         = vecs[i].rs1;
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), {63'd0, bus.rf_we_out}, {63'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_waddr", i), {59'd0, bus.rf_waddr_out}, {59'd0, vecs[i].rd});
                chk($sformatf("vec%0d_wdata", i), bus.rf_wdata_out, vecs[i].exp_wdata);
            end
            chk($sformatf("vec%0d_stall", i), {63'd0, bus.wb_stall}, 64'd0);
            chk($sformatf("vec%0d_rs1", i), bus.rs1_data, vecs[i].exp_rs1);
            next_cycle();
            exp_instret++;
            chk($sformatf("vec%0d_instret", i), bus.instret, exp_instret);
        end

        // Array contents after the table (no bypass active).
        idle_inputs();
        bus.rs1_addr = 5'd6;
        bus.rs2_addr = 5'd10;
        #1;
        chk("array_x6", bus.rs1_data, 64'h80);
        chk("array_x10", bus.rs2_data, 64'h8765_4321);

        // Miss load: three stall cycles, then LW at offset 4 using latched fields.
        drive_load(5'd15, 2'b10, 1'b0, 3'd4, 1'b0, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("miss_stall_c%0d", c), {63'd0, bus.wb_stall}, 64'd1);
            chk($sformatf("miss_we_c%0d", c), {63'd0, bus.rf_we_out}, 64'd0);
            next_cycle();
            // Upstream fields change while waiting; the latched copy must be used.
            bus.rd_in           = 5'd3;
            bus.load_size_in    = 2'b00;
            bus.load_addr_lo_in = 3'd0;
        end
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 64'h8765_4321_0000_0000;
        @(negedge clk);
        chk("miss_done_stall", {63'd0, bus.wb_stall}, 64'd0);
        chk("miss_done_we", {63'd0, bus.rf_we_out}, 64'd1);
        chk("miss_done_waddr", {59'd0, bus.rf_waddr_out}, 64'd15);
        chk("miss_done_wdata", bus.rf_wdata_out, 64'hFFFF_FFFF_8765_4321);
        next_cycle();
        exp_instret++;
        idle_inputs();
        bus.rs1_addr = 5'd15;
        #1;
        chk("miss_instret", bus.instret, exp_instret);
        chk("miss_x15", bus.rs1_data, 64'hFFFF_FFFF_8765_4321);

        // Preload x7, then flush in IDLE suppresses a commit.
        bus.wb_valid_in   = 1'b1;
        bus.reg_write_in  = 1'b1;
        bus.rd_in         = 5'd7;
        bus.alu_result_in = 64'h77;
        next_cycle();
        exp_instret++;
        bus.alu_result_in = 64'h99;
        bus.flush         = 1'b1;
        @(negedge clk);
        chk("flush_idle_we", {63'd0, bus.rf_we_out}, 64'd0);
        next_cycle();
        bus.flush = 1'b0;

        // Flush during WAIT_MEM drops the load.
        drive_load(5'd7, 2'b11, 1'b0, 3'd0, 1'b0, 64'h0);
        @(negedge clk);
        chk("wflush_stall_c1", {63'd0, bus.wb_stall}, 64'd1);
        next_cycle();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("wflush_stall_c2", {63'd0, bus.wb_stall}, 64'd0);
        chk("wflush_we_c2", {63'd0, bus.rf_we_out}, 64'd0);
        next_cycle();
        idle_inputs();
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.rs1_addr        = 5'd7;
        @(negedge clk);
        chk("wflush_idle_we", {63'd0, bus.rf_we_out}, 64'd0);
        chk("wflush_idle_stall", {63'd0, bus.wb_stall}, 64'd0);
        chk("wflush_x7", bus.rs1_data, 64'h77);
        chk("wflush_instret", bus.instret, exp_instret);
        next_cycle();

        // Async reset while a load is pending, asserted between edges.
        drive_load(5'd16, 2'b11, 1'b0, 3'd0, 1'b0, 64'h0);
        @(negedge clk);
        chk("rst_pre_stall", {63'd0, bus.wb_stall}, 64'd1);
        #2 reset = 1'b1;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd7;
        #1;
        chk("rst_stall", {63'd0, bus.wb_stall}, 64'd0);
        chk("rst_we", {63'd0, bus.rf_we_out}, 64'd0);
        chk("rst_instret", bus.instret, 64'd0);
        chk("rst_x5", bus.rs1_data, 64'd0);
        chk("rst_x7", bus.rs2_data, 64'd0);
        idle_inputs();
        bus.rs1_addr = 5'd16;
        #3 reset = 1'b0;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 64'h1111_2222_3333_4444;
        @(negedge clk);
        chk("post_rst_we", {63'd0, bus.rf_we_out}, 64'd0);
        next_cycle();
        chk("post_rst_x16", bus.rs1_data, 64'd0);
        chk("post_rst_instret", bus.instret, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
